// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C SCL generator.
package i2c_pkg;

    typedef enum logic [1:0] {
        PH_LOW_A  = 2'd0,
        PH_LOW_B  = 2'd1,
        PH_HIGH_A = 2'd2,
        PH_HIGH_B = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    localparam int unsigned I2C_MIN_DIV  = 4;
    localparam int unsigned I2C_SYNC_LAT = 2;

endpackage

// File: rtl/i2c_scl_sync.sv
// Multi-flop synchroniser bringing the SCL pad into the clk domain; idles high.
module i2c_scl_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    output logic scl_s
);

    logic [I2C_SYNC_LAT-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[I2C_SYNC_LAT-2:0], scl_in};
        end
    end

    assign scl_s = sync_q[I2C_SYNC_LAT-1];

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C master SCL / data-clock generator with bus-sampled clock stretching.
// Optional stretch timeout enabled by defining I2C_STRETCH_TIMEOUT_EN.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int DIV_W = 12,
    parameter int TO_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [DIV_W-1:0] div,
    input  logic             scl_in,
    input  logic             scl_not_ena,
    input  logic [TO_W-1:0]  timeout_lim,
    output logic             scl_oe,
    output logic             data_clk,
    output logic [1:0]       phase,
    output logic             switch_range,
    output logic             stretch,
    output logic             timeout
);

    state_t           st, st_n;
    phase_t           ph, ph_n;
    logic [DIV_W-1:0] cnt, cnt_n, div_q, div_n, div_clamp, cnt_last;
    logic             scl_s, hold, wrap, to_hit, run_n;

    i2c_scl_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .scl_in (scl_in),
        .scl_s  (scl_s)
    );

    assign div_clamp = (div < DIV_W'(I2C_MIN_DIV)) ? DIV_W'(I2C_MIN_DIV) : div;
    assign cnt_last  = div_q - DIV_W'(1);
    assign wrap      = (st == ST_RUN) && (ph == PH_HIGH_B) && (cnt == cnt_last);
    // Holding at cnt==SYNC_LAT hides the synchroniser delay after releasing SCL.
    assign hold      = (st == ST_RUN) && (ph == PH_HIGH_A) && (cnt == DIV_W'(I2C_SYNC_LAT))
                       && !scl_s && !scl_not_ena;

`ifdef I2C_STRETCH_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt, to_inc;

    assign to_inc = to_cnt + TO_W'(1);
    assign to_hit = hold && (timeout_lim != '0) && (to_inc == timeout_lim);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            if (st != ST_RUN || wrap) begin
                to_cnt <= '0;
            end else if (hold) begin
                to_cnt <= to_inc;
            end
            if (to_hit) begin
                timeout <= 1'b1;
            end else if (st == ST_TIMEOUT && !ena) begin
                timeout <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_lim;

    assign unused_timeout_lim = ^timeout_lim;
    assign to_hit             = 1'b0;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        st_n  = st;
        ph_n  = ph;
        cnt_n = cnt;
        div_n = div_q;
        case (st)
            ST_IDLE: begin
                ph_n  = PH_LOW_A;
                cnt_n = '0;
                if (ena) begin
                    st_n  = ST_RUN;
                    div_n = div_clamp;
                end
            end
            ST_RUN: begin
                if (to_hit) begin
                    st_n  = ST_TIMEOUT;
                    ph_n  = PH_LOW_A;
                    cnt_n = '0;
                end else if (hold) begin
                    cnt_n = cnt;
                end else if (cnt == cnt_last) begin
                    cnt_n = '0;
                    if (ph == PH_HIGH_B) begin
                        ph_n = PH_LOW_A;
                        if (ena) begin
                            div_n = div_clamp;
                        end else begin
                            st_n = ST_IDLE;
                        end
                    end else begin
                        ph_n = phase_t'(ph + 2'd1);
                    end
                end else begin
                    cnt_n = cnt + DIV_W'(1);
                end
            end
`ifdef I2C_STRETCH_TIMEOUT_EN
            ST_TIMEOUT: begin
                ph_n  = PH_LOW_A;
                cnt_n = '0;
                if (!ena) begin
                    st_n = ST_IDLE;
                end
            end
`endif
            default: begin
                st_n  = ST_IDLE;
                ph_n  = PH_LOW_A;
                cnt_n = '0;
            end
        endcase
    end

    assign run_n = (st_n == ST_RUN);

    // Outputs are registered from next-state values so they change with the phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st           <= ST_IDLE;
            ph           <= PH_LOW_A;
            cnt          <= '0;
            div_q        <= '0;
            scl_oe       <= 1'b0;
            data_clk     <= 1'b0;
            switch_range <= 1'b0;
            stretch      <= 1'b0;
        end else begin
            st           <= st_n;
            ph           <= ph_n;
            cnt          <= cnt_n;
            div_q        <= div_n;
            scl_oe       <= run_n && (ph_n == PH_LOW_A || ph_n == PH_LOW_B);
            data_clk     <= run_n && (ph_n == PH_LOW_B || ph_n == PH_HIGH_A);
            switch_range <= run_n && (ph_n == PH_HIGH_A);
            stretch      <= hold && !to_hit;
        end
    end

    assign phase = ph;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: period shape, stretching, div reload, ena drop, reset.
module tb_i2c_scl_gen;

    localparam int DIV_W = 12;
    localparam int TO_W  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ena = 1'b0;
    logic             scl_not_ena = 1'b0;
    logic             hold_low = 1'b0;
    logic [DIV_W-1:0] div = 12'd4;
    logic [TO_W-1:0]  timeout_lim = '0;
    logic             scl_in, scl_oe, data_clk, switch_range, stretch, timeout;
    logic [1:0]       phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Open-drain bus: low if the master or a slave pulls it.
    assign scl_in = !scl_oe && !hold_low;

    i2c_scl_gen #(.DIV_W(DIV_W), .TO_W(TO_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .div          (div),
        .scl_in       (scl_in),
        .scl_not_ena  (scl_not_ena),
        .timeout_lim  (timeout_lim),
        .scl_oe       (scl_oe),
        .data_clk     (data_clk),
        .phase        (phase),
        .switch_range (switch_range),
        .stretch      (stretch),
        .timeout      (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts at the first sample of a period; runs to the first sample of the next one.
    task automatic run_period(input int rel_at, input int act,
                              output int per, output int sr, output int st, output int bad);
        logic [1:0] prev;
        int         ph2;
        bit         acted;
        per = 0; sr = 0; st = 0; bad = 0; ph2 = 0; acted = 0;
        prev = phase;
        for (int n = 0; n < 400; n++) begin
            if (switch_range) sr++;
            if (stretch) st++;
            if (stretch && !switch_range) bad++;
            if (phase == 2'd2) ph2++;
            if (rel_at != 0 && ph2 == rel_at) hold_low = 1'b0;
            if (!acted && phase == 2'd1) begin
                acted = 1;
                if (act == 1) div = 12'd5;
                else if (act == 2) ena = 1'b0;
            end
            prev = phase;
            tick();
            per++;
            if (prev == 2'd3 && phase == 2'd0) break;
        end
        check("period_end", {prev, phase}, {2'd3, 2'd0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         per, sr, st, bad, since;
        logic [1:0] eph;

        #12;
        check("rst_outputs", {scl_oe, data_clk, phase, switch_range, stretch, timeout}, 32'd0);

        // Basic 16-cycle period at div=4.
        ena = 1'b1;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            eph = 2'(i / 4);
            check("p16_outputs", {phase, data_clk, scl_oe, switch_range, stretch},
                  {eph, (eph == 2'd1 || eph == 2'd2), (eph < 2'd2), (eph == 2'd2), 1'b0});
            tick();
        end
        check("p16_wrap", {phase, scl_oe}, {2'd0, 1'b1});

        // div change mid-period is deferred to the next period.
        div = 12'd8;
        run_period(0, 0, per, sr, st, bad);
        check("div_deferred_per", per, 16);

        // Slave holds SCL low 10 cycles after release.
        hold_low = 1'b1;
        run_period(11, 0, per, sr, st, bad);
        check("str_period", per, 42);
        check("str_switch_range", sr, 18);
        check("str_stretch", st, 10);
        check("str_outside_high", bad, 0);

        // Stretch check disabled with SCL stuck low.
        scl_not_ena = 1'b1;
        hold_low    = 1'b1;
        run_period(0, 0, per, sr, st, bad);
        check("nse_period", per, 32);
        check("nse_stretch", st, 0);
        hold_low    = 1'b0;
        scl_not_ena = 1'b0;

        timeout_lim = 16'd20;
        hold_low    = 1'b1;
`ifdef I2C_STRETCH_TIMEOUT_EN
        since = -1;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (since >= 0) since++;
            else if (phase == 2'd2) since = 0;
            if (timeout) break;
        end
        check("to_flag", timeout, 1);
        check("to_delay", since, 22);
        check("to_outputs", {scl_oe, phase, data_clk, stretch}, 32'd0);
        repeat (5) tick();
        check("to_sticky", {timeout, scl_oe, phase}, {1'b1, 1'b0, 2'd0});
        ena = 1'b0;
        tick();
        check("to_clear", timeout, 0);
        hold_low = 1'b0;
        ena      = 1'b1;
        tick();
        check("to_restart", {scl_oe, phase}, {1'b1, 2'd0});
`else
        since = 0;
        repeat (60) tick();
        check("nt_stuck", {timeout, stretch, scl_oe, phase}, {1'b0, 1'b1, 1'b0, 2'd2});
        hold_low = 1'b0;
        run_period(0, 0, per, sr, st, bad);
`endif
        timeout_lim = '0;

        // div 8->5 in phase 1, then ena dropped in phase 1 of the next period.
        run_period(0, 1, per, sr, st, bad);
        check("reload_cur_per", per, 32);
        run_period(0, 2, per, sr, st, bad);
        check("reload_next_per", per, 20);
        check("idle_after", {scl_oe, data_clk, phase, switch_range}, 32'd0);
        repeat (3) tick();
        check("idle_hold", scl_oe, 0);

        // div below the minimum behaves as 4.
        div = 12'd2;
        ena = 1'b1;
        tick();
        run_period(0, 0, per, sr, st, bad);
        check("min_div_per", per, 16);

        // Asynchronous reset in the middle of phase 1.
        for (int n = 0; n < 40; n++) begin
            if (phase == 2'd1) break;
            tick();
        end
        check("rst_mid_phase", phase, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_async", {scl_oe, data_clk, phase, switch_range, stretch, timeout}, 32'd0);
        rst = 1'b1;
        tick();
        check("rst_restart", {phase, scl_oe}, {2'd0, 1'b1});
        repeat (4) tick();
        check("rst_restart_ph1", {phase, data_clk}, {2'd1, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_scl_gen.md
# i2c_scl_gen

Parametrised I2C master SCL/data-clock generator with programmable rate, bus-sampled clock stretching and an optional stretch timeout. It sits between the I2C byte/bit sequencer, which consumes `data_clk`, `phase` and `switch_range`, and the open-drain SCL pad, which it drives via `scl_oe` and samples via `scl_in`. A bus SCL period is four quarter-phases of `div` cycles each, plus any cycles a slave holds SCL low.

## Interface
- `DIV_W`, 12: width of the quarter-period divider and counter.
- `TO_W`, 16: width of the stretch timeout counter and limit.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  run enable from the sequencer.
- `div`  in  DIV_W  quarter-period length in `clk` cycles; legal range 4..2^DIV_W-1; values below 4 are treated as 4.
- `scl_in`  in  1  raw SCL pad input; asynchronous to `clk`.
- `scl_not_ena`  in  1  1 = SCL not driven by the master this period; the stretch check is disabled.
- `timeout_lim`  in  TO_W  maximum stretch cycles per period.
- `scl_oe`  out  1  1 = pull SCL low; 0 = release.
- `data_clk`  out  1  SDA timing clock for the sequencer.
- `phase`  out  2  current quarter: 0, 1, 2 or 3.
- `switch_range`  out  1  1 while `phase`==2, the SCL-high window.
- `stretch`  out  1  1 while the counter is held by a low bus SCL.
- `timeout`  out  1  sticky stretch-timeout error.

## Operation
- States: IDLE, RUN, TIMEOUT.
- **IDLE**
  - `cnt`=0, `phase`=0, `scl_oe`=0, `data_clk`=0.
  - `ena`=1 → RUN at phase 0, cnt 0, latching `div` into `div_q`.
- **RUN**
  - `cnt` counts 0..`div_q`-1. At `div_q`-1, `cnt` wraps to 0 and `phase` advances 0→1→2→3→0.
  - Outputs per phase: 0: `scl_oe`=1, `data_clk`=0. 1: `scl_oe`=1, `data_clk`=1. 2: `scl_oe`=0, `data_clk`=1. 3: `scl_oe`=0, `data_clk`=0.
  - `div_q` reloads from `div` only on the 3→0 wrap; a mid-period change of `div` has no effect until the next period.
  - `ena`=0 takes effect at the next 3→0 wrap: go to IDLE instead of phase 0. A period in progress always completes.
- **Stretch**
  - Condition: `phase`==2, `cnt`==2, synchronised SCL `scl_s`==0 and `scl_not_ena`==0.
  - While the condition holds, `cnt` holds and `stretch`=1.
  - Holding at `cnt`==2 covers the 2-cycle synchroniser latency, so a bus that follows the release is not seen as a stretch.
- **Timeout**
  - Per-period stretch counter `to_cnt` clears on each 3→0 wrap and increments each stretch cycle.
  - When `to_cnt` reaches `timeout_lim`: `timeout`=1, go to TIMEOUT, and outputs take IDLE values.
  - TIMEOUT → IDLE only when `ena`=0; `timeout` clears on that transition.
  - `timeout_lim`=0 disables the timeout.
- Counter arithmetic is unsigned and width-exact; `cnt` never exceeds `div_q`-1.

## Timing
- Reset values: `scl_oe`=0, `data_clk`=0, `phase`=0, `switch_range`=0, `stretch`=0, `timeout`=0, `cnt`=0, `to_cnt`=0, synchroniser flops=1.
- Reset is asynchronous and takes effect mid-operation; SCL is released immediately.
- All outputs are registered.
- `ena` rise sampled in IDLE → `scl_oe`=1 on the next edge.
- Unstretched period: exactly 4·`div_q` cycles.
- With the bus SCL held low N cycles after release: period = 4·`div_q` + N, and `stretch` is high for N cycles.
- `stretch` rises only while `switch_range`=1.
- Simultaneous events:
  - Timeout and a 3→0 wrap in the same cycle: timeout wins.
  - `ena`=0 during a stretch: the stretch continues and the period completes.

## Configuration
- Macro `I2C_STRETCH_TIMEOUT_EN`.
- Defined: timeout counter, TIMEOUT state and `timeout` output are present, as described above.
- Undefined: no `to_cnt`, no TIMEOUT state; `timeout` is tied to 0 and `timeout_lim` is ignored; stretching is unbounded. Port list is unchanged.

## Structure
- Package `i2c_pkg`: typedef for the phase enum (PH_LOW_A, PH_LOW_B, PH_HIGH_A, PH_HIGH_B), the state enum (ST_IDLE, ST_RUN, ST_TIMEOUT), and constants `I2C_MIN_DIV`=4 and `I2C_SYNC_LAT`=2.
- One sub-module, `i2c_scl_sync`: 2-flop synchroniser from `scl_in` to `scl_s`; reset value 1.

## Test plan
- `div`=4, `ena`=1, `scl_in`=!`scl_oe` → period 16 cycles; `phase` 0,1,2,3 for 4 cycles each; `data_clk` high in phases 1–2; `stretch` never asserted.
- `div`=8, `scl_in` held low 10 cycles after phase-2 entry → `stretch` high 10 cycles, period 42, `switch_range` high 18 cycles.
- `scl_not_ena`=1 and `scl_in`=0 constantly → no stretch; period exactly 4·`div`.
- Macro defined, `timeout_lim`=20, `scl_in` stuck low → `timeout`=1 after 20 stretch cycles; `scl_oe`=0, `phase`=0; holds until `ena`=0, then clears.
- `div` changed 8→5 in phase 1, and `ena` dropped in phase 1 of the next period → current period stays 32 cycles, next period is 20 cycles, then IDLE.
- `rst` asserted mid-phase 1 → all outputs at reset values before the next clock edge; restart begins at phase 0.
